// File: rtl/sdram_aref_sched_if.sv
// rtl/sdram_aref_sched_if.sv - arbiter-facing bus of the SDRAM auto-refresh scheduler
interface sdram_aref_sched_if #(
    parameter int ADDR_W = 13
);
    logic              flag_init_end;
    logic              ref_en;
    logic              ref_req;
    logic              ref_urgent;
    logic              flag_ref_end;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [3:0]        debt;
    logic              debt_ovf;

    modport master (
        input  flag_init_end, ref_en,
        output ref_req, ref_urgent, flag_ref_end, aref_cmd, sdram_addr, debt, debt_ovf
    );

    modport slave (
        output flag_init_end, ref_en,
        input  ref_req, ref_urgent, flag_ref_end, aref_cmd, sdram_addr, debt, debt_ovf
    );
endinterface

// File: rtl/sdram_aref_sched.sv
// rtl/sdram_aref_sched.sv - auto-refresh scheduler: credit counter plus PRE/AREF burst FSM
module sdram_aref_sched #(
    parameter int REF_INTERVAL   = 349,
    parameter int AREF_PER_GRANT = 2,
    parameter int T_RP           = 2,
    parameter int T_RFC          = 4,
    parameter int PRE_EN         = 1,
    parameter int MAX_DEBT       = 8,
    parameter int ADDR_W         = 13
) (
    input  logic                sclk,
    input  logic                s_rst,
    sdram_aref_sched_if.master  bus
);
    localparam int ICNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(REF_INTERVAL - 1);
    localparam logic [3:0]  MAXD     = 4'(MAX_DEBT);
    localparam logic [3:0]  APG      = 4'(AREF_PER_GRANT);
    localparam logic [15:0] RP_LOAD  = 16'(T_RP - 2);
    localparam logic [15:0] RFC_LOAD = 16'(T_RFC - 2);
    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [3:0]  CMD_PRE  = 4'b0010;
    localparam logic [3:0]  CMD_AREF = 4'b0001;
    localparam logic [ADDR_W-1:0] ADDR_ALL_BANKS = ADDR_W'(11'h400);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_PRE_WAIT, S_AREF, S_AREF_WAIT, S_DONE
    } state_t;

    state_t            state;
    logic [ICNT_W-1:0] icnt;
    logic [3:0]        debt_q;
    logic              ovf_q;
    logic [3:0]        cmd_q;
    logic              req_q;
    logic              end_q;
    logic [3:0]        burst;
    logic [15:0]       wcnt;
    logic              tick;
    logic              aref_now;

    assign tick     = bus.flag_init_end && (icnt == ICNT_LAST);
    assign aref_now = (cmd_q == CMD_AREF);

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            icnt   <= '0;
            debt_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (!bus.flag_init_end || tick) icnt <= '0;
            else                            icnt <= icnt + 1'b1;
            // A credit earned and spent in the same cycle cancels out.
            if (tick && !aref_now) begin
                if (debt_q == MAXD) ovf_q  <= 1'b1;
                else                debt_q <= debt_q + 4'd1;
            end else if (aref_now && !tick && debt_q != 4'd0) begin
                debt_q <= debt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state <= S_IDLE;
            cmd_q <= CMD_NOP;
            req_q <= 1'b0;
            end_q <= 1'b0;
            burst <= '0;
            wcnt  <= '0;
        end else begin
            cmd_q <= CMD_NOP;
            end_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_q && bus.ref_en) begin
                        req_q <= 1'b0;
                        if (PRE_EN != 0) begin
                            state <= S_PRE;
                            cmd_q <= CMD_PRE;
                        end else begin
                            state <= S_AREF;
                            cmd_q <= CMD_AREF;
                        end
                    end else begin
                        req_q <= (debt_q != 4'd0);
                    end
                end
                S_PRE: begin
                    if (T_RP == 1) begin
                        state <= S_AREF;
                        cmd_q <= CMD_AREF;
                    end else begin
                        state <= S_PRE_WAIT;
                        wcnt  <= RP_LOAD;
                    end
                end
                S_PRE_WAIT: begin
                    if (wcnt == 16'd0) begin
                        state <= S_AREF;
                        cmd_q <= CMD_AREF;
                    end else begin
                        wcnt <= wcnt - 16'd1;
                    end
                end
                S_AREF: begin
                    burst <= burst + 4'd1;
                    state <= S_AREF_WAIT;
                    wcnt  <= RFC_LOAD;
                end
                S_AREF_WAIT: begin
                    // debt_q already reflects the AREF that opened this wait window.
                    if (wcnt == 16'd0) begin
                        if (burst < APG && debt_q != 4'd0) begin
                            state <= S_AREF;
                            cmd_q <= CMD_AREF;
                        end else begin
                            state <= S_DONE;
                            end_q <= 1'b1;
                        end
                    end else begin
                        wcnt <= wcnt - 16'd1;
                    end
                end
                S_DONE: begin
                    burst <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ref_req      = req_q;
    assign bus.ref_urgent   = (debt_q >= MAXD - 4'd1);
    assign bus.flag_ref_end = end_q;
    assign bus.aref_cmd     = cmd_q;
    assign bus.sdram_addr   = ADDR_ALL_BANKS;
    assign bus.debt         = debt_q;
    assign bus.debt_ovf     = ovf_q;
endmodule

// File: tb/tb_sdram_aref_sched.sv
// tb/tb_sdram_aref_sched.sv - randomized bench with timeline reference model for sdram_aref_sched
module tb_sdram_aref_sched;
    localparam int RI    = 349;
    localparam int T_RP  = 2;
    localparam int T_RFC = 4;
    localparam int MAXD  = 8;
    localparam int NOP   = 4'b0111;
    localparam int PRE   = 4'b0010;
    localparam int AREF  = 4'b0001;

    logic sclk = 1'b0;
    logic s_rst = 1'b0;
    logic init = 1'b0;
    logic en [2];

    int n_pass = 0;
    int n_total = 0;

    sdram_aref_sched_if #(.ADDR_W(13)) bus_a ();
    sdram_aref_sched_if #(.ADDR_W(13)) bus_b ();

    assign bus_a.flag_init_end = init;
    assign bus_b.flag_init_end = init;
    assign bus_a.ref_en = en[0];
    assign bus_b.ref_en = en[1];

    sdram_aref_sched #(
        .REF_INTERVAL(RI), .AREF_PER_GRANT(2), .T_RP(T_RP), .T_RFC(T_RFC),
        .PRE_EN(1), .MAX_DEBT(MAXD), .ADDR_W(13)
    ) u_dut_a (.sclk(sclk), .s_rst(s_rst), .bus(bus_a));

    sdram_aref_sched #(
        .REF_INTERVAL(RI), .AREF_PER_GRANT(4), .T_RP(T_RP), .T_RFC(T_RFC),
        .PRE_EN(0), .MAX_DEBT(MAXD), .ADDR_W(13)
    ) u_dut_b (.sclk(sclk), .s_rst(s_rst), .bus(bus_b));

    always #5 sclk = ~sclk;

    logic [3:0] o_cmd [2];
    logic       o_req [2];
    logic       o_end [2];
    logic [3:0] o_debt [2];
    logic       o_ovf [2];
    logic       o_urg [2];
    assign o_cmd[0] = bus_a.aref_cmd;     assign o_cmd[1] = bus_b.aref_cmd;
    assign o_req[0] = bus_a.ref_req;      assign o_req[1] = bus_b.ref_req;
    assign o_end[0] = bus_a.flag_ref_end; assign o_end[1] = bus_b.flag_ref_end;
    assign o_debt[0] = bus_a.debt;        assign o_debt[1] = bus_b.debt;
    assign o_ovf[0] = bus_a.debt_ovf;     assign o_ovf[1] = bus_b.debt_ovf;
    assign o_urg[0] = bus_a.ref_urgent;   assign o_urg[1] = bus_b.ref_urgent;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: credits as plain integers, grant as a timeline of offsets since grant.
    int p_pre [2] = '{1, 0};
    int p_apg [2] = '{2, 4};
    int m_icnt [2], m_debt [2], m_ovf [2], m_req [2], m_cmd [2], m_end [2];
    int m_ing [2], m_t [2], m_next [2], m_last [2], m_endt [2], m_arefs [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_icnt[d] = 0; m_debt[d] = 0; m_ovf[d] = 0; m_req[d] = 0;
            m_cmd[d] = NOP; m_end[d] = 0; m_ing[d] = 0; m_t[d] = 0;
            m_next[d] = -1; m_last[d] = -100; m_endt[d] = -1; m_arefs[d] = 0;
        end
    endtask

    task automatic model_edge(input int d);
        int nd;
        bit tick, was_aref;
        tick = init && (m_icnt[d] == RI - 1);
        was_aref = (m_cmd[d] == AREF);
        nd = m_debt[d];
        if (tick && !was_aref) begin
            if (nd == MAXD) m_ovf[d] = 1;
            else nd++;
        end else if (was_aref && !tick && nd > 0) begin
            nd--;
        end
        m_icnt[d] = (!init || tick) ? 0 : m_icnt[d] + 1;
        if (m_ing[d] == 0) begin
            if (m_req[d] != 0 && en[d]) begin
                m_ing[d] = 1; m_t[d] = 0; m_arefs[d] = 0; m_last[d] = -100; m_endt[d] = -1;
                m_next[d] = (p_pre[d] != 0) ? T_RP : 0;
                m_req[d] = 0;
            end else begin
                m_req[d] = (m_debt[d] != 0);
            end
        end else if (m_t[d] == m_endt[d]) begin
            m_ing[d] = 0;
        end else begin
            if (was_aref) begin
                m_arefs[d]++;
                m_last[d] = m_t[d];
            end
            m_t[d]++;
            if (m_t[d] == m_last[d] + T_RFC) begin
                if (m_arefs[d] < p_apg[d] && m_debt[d] != 0) m_next[d] = m_t[d];
                else m_endt[d] = m_t[d];
            end
        end
        if (m_ing[d] != 0) begin
            m_cmd[d] = (m_t[d] == 0 && p_pre[d] != 0) ? PRE : (m_t[d] == m_next[d]) ? AREF : NOP;
            m_end[d] = (m_t[d] == m_endt[d]);
        end else begin
            m_cmd[d] = NOP;
            m_end[d] = 0;
        end
        m_debt[d] = nd;
    endtask

    always @(posedge sclk) begin
        if (!s_rst) begin
            model_edge(0);
            model_edge(1);
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("cmd%0d", d), o_cmd[d], m_cmd[d]);
                check($sformatf("ref_req%0d", d), o_req[d], m_req[d]);
                check($sformatf("ref_end%0d", d), o_end[d], m_end[d]);
                check($sformatf("debt%0d", d), o_debt[d], m_debt[d]);
                check($sformatf("ovf%0d", d), o_ovf[d], m_ovf[d]);
                check($sformatf("urgent%0d", d), o_urg[d], m_debt[d] >= MAXD - 1);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_req%0d", tag, d), o_req[d], 0);
            check($sformatf("%s_urg%0d", tag, d), o_urg[d], 0);
            check($sformatf("%s_end%0d", tag, d), o_end[d], 0);
            check($sformatf("%s_cmd%0d", tag, d), o_cmd[d], NOP);
            check($sformatf("%s_debt%0d", tag, d), o_debt[d], 0);
            check($sformatf("%s_ovf%0d", tag, d), o_ovf[d], 0);
        end
    endtask

    initial begin
        bit found;
        int exp_cmd;
        logic [3:0] d0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        model_reset();
        #1 s_rst = 1'b1;
        repeat (3) @(negedge sclk);
        check_reset_outputs("rst");
        s_rst = 1'b0;

        repeat (2000) @(negedge sclk);
        check("addr_a", bus_a.sdram_addr, 32'h400);
        check("addr_b", bus_b.sdram_addr, 32'h400);
        check("idle_debt", o_debt[0], 0);

        init = 1'b1;
        repeat (349) @(negedge sclk);
        check("debt_after_349", o_debt[0], 1);
        check("req_before", o_req[0], 0);
        @(negedge sclk);
        check("req_after_credit", o_req[0], 1);
        repeat (348) @(negedge sclk);
        check("debt_after_698", o_debt[0], 2);

        en[0] = 1'b1;
        @(negedge sclk);
        en[0] = 1'b0;
        for (int j = 0; j < 12; j++) begin
            exp_cmd = (j == 0) ? PRE : (j == 2 || j == 6) ? AREF : NOP;
            check($sformatf("a_burst_cmd_j%0d", j), o_cmd[0], exp_cmd);
            check($sformatf("a_burst_end_j%0d", j), o_end[0], j == 10);
            check($sformatf("a_burst_req_j%0d", j), o_req[0], 0);
            if (j == 11) check("a_burst_debt", o_debt[0], 0);
            @(negedge sclk);
        end

        repeat (400) @(negedge sclk);
        check("b_debt3", o_debt[1], 3);
        en[1] = 1'b1;
        @(negedge sclk);
        en[1] = 1'b0;
        for (int j = 0; j < 15; j++) begin
            exp_cmd = (j == 0 || j == 4 || j == 8) ? AREF : NOP;
            check($sformatf("b_burst_cmd_j%0d", j), o_cmd[1], exp_cmd);
            check($sformatf("b_burst_end_j%0d", j), o_end[1], j == 12);
            check($sformatf("b_burst_req_j%0d", j), o_req[1], 0);
            if (j == 13) check("b_burst_debt", o_debt[1], 0);
            @(negedge sclk);
        end

        repeat (10 * RI) @(negedge sclk);
        check("sat_debt", o_debt[0], MAXD);
        check("sat_ovf", o_ovf[0], 1);
        check("sat_urgent", o_urg[0], 1);
        en[0] = 1'b1;
        @(negedge sclk);
        en[0] = 1'b0;
        repeat (14) @(negedge sclk);
        check("ovf_sticky", o_ovf[0], 1);

        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_icnt[0] == RI - 4 && o_req[0]) found = 1;
            else @(negedge sclk);
        end
        check("tick_align_found", found, 1);
        en[0] = 1'b1;
        @(negedge sclk);
        en[0] = 1'b0;
        repeat (2) @(negedge sclk);
        check("tick_aref_cmd", o_cmd[0], AREF);
        d0 = o_debt[0];
        @(negedge sclk);
        check("tick_aref_debt", o_debt[0], d0);
        repeat (12) @(negedge sclk);

        for (int i = 0; i < 8000; i++) begin
            en[0] = ($urandom_range(0, 7) == 0);
            en[1] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 599) == 0) init = ~init;
            @(negedge sclk);
        end
        en[0] = 1'b0;
        en[1] = 1'b0;
        init = 1'b1;

        found = 0;
        for (int i = 0; i < 1500 && !found; i++) begin
            if (o_req[0]) found = 1;
            else @(negedge sclk);
        end
        check("rst_wait_req", found, 1);
        en[0] = 1'b1;
        @(negedge sclk);
        en[0] = 1'b0;
        repeat (2) @(negedge sclk);
        check("rst_pre_aref", o_cmd[0], AREF);
        @(negedge sclk);
        #2 s_rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge sclk);
        s_rst = 1'b0;
        @(negedge sclk);
        check("post_rst_req", o_req[0], 0);
        check("post_rst_cmd", o_cmd[0], NOP);
        repeat (50) @(negedge sclk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sdram_aref_sched.md
# sdram_aref_sched

Parametrised SDRAM auto-refresh scheduler. It accumulates refresh credits ("debt") from a periodic interval timer. It requests the command bus from the SDRAM arbiter and, per grant, issues an optional PRECHARGE ALL followed by a burst of AUTO REFRESH commands, honouring tRP and tRFC. Postponed refreshes are tracked up to a configurable limit, with urgency and overflow flags for the arbiter.

## Interface
- REF_INTERVAL, 349: clock cycles per refresh credit (7 µs at 50 MHz); ≥ 16.
- AREF_PER_GRANT, 2: maximum AREF commands per grant; 1..8.
- T_RP, 2: cycles from PRECHARGE to next command; ≥ 1.
- T_RFC, 4: cycles from AREF to next command; ≥ 2.
- PRE_EN, 1: 1 = precharge-all precedes the AREF burst; 0 = AREF only.
- MAX_DEBT, 8: debt saturation value; 2..15.
- ADDR_W, 13: SDRAM address width; ≥ 11.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- s_rst  in  1  asynchronous, active-high reset.
- flag_init_end  in  1  SDRAM init done; interval timer runs only while high.
- ref_en  in  1  arbiter grant.
- ref_req  out  1  refresh request to arbiter.
- ref_urgent  out  1  debt ≥ MAX_DEBT-1.
- flag_ref_end  out  1  one-cycle pulse, grant finished, bus released.
- aref_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: NOP 4'b0111, PRE 4'b0010, AREF 4'b0001.
- sdram_addr  out  ADDR_W  constant; bit 10 = 1 (all banks), all other bits 0.
- debt  out  4  outstanding refresh credits.
- debt_ovf  out  1  sticky; a credit was lost at saturation.

## Operation
- Interval counter: 0..REF_INTERVAL-1 while flag_init_end=1. At REF_INTERVAL-1 it wraps to 0 and produces a one-cycle tick. Held at 0 while flag_init_end=0.
- Debt counter:
  - +1 on tick; -1 on each cycle aref_cmd=AREF.
  - Tick and AREF in the same cycle: unchanged.
  - Tick at debt=MAX_DEBT with no AREF: stays MAX_DEBT, debt_ovf←1.
  - Never decrements below 0.
- FSM states: IDLE, PRE, PRE_WAIT, AREF, AREF_WAIT, DONE.
  - IDLE: ref_req = (debt≠0). ref_en=1 with ref_req=1 → PRE if PRE_EN=1, else AREF. ref_en while ref_req=0 is ignored.
  - PRE: aref_cmd=PRE for 1 cycle → PRE_WAIT.
  - PRE_WAIT: NOP for T_RP-1 cycles → AREF.
  - AREF: aref_cmd=AREF for 1 cycle; burst count +1 → AREF_WAIT.
  - AREF_WAIT: NOP for T_RFC-1 cycles. Then → AREF if burst count < AREF_PER_GRANT and debt ≠ 0; else → DONE.
  - DONE: flag_ref_end=1 for 1 cycle; burst count cleared → IDLE.
- ref_req deasserts on the edge that samples ref_en=1. It stays low until the FSM re-enters IDLE; it may re-assert the cycle after DONE if debt ≠ 0.
- ref_urgent is combinational from debt.
- flag_init_end falling mid-grant: the grant completes normally; only the interval counter clears.
- debt_ovf is cleared only by s_rst.

## Timing
- Reset values (asynchronous, immediate on s_rst=1):
  - ref_req=0, ref_urgent=0, flag_ref_end=0, aref_cmd=4'b0111, debt=0, debt_ovf=0.
  - FSM=IDLE; interval and burst counters = 0.
- Registered outputs: aref_cmd, ref_req, flag_ref_end and debt are registered, and aref_cmd is aligned with the FSM state.
- Grant latency: grant sampled at edge k → first command (PRE or AREF) valid from edge k+1.
- Grant length with PRE_EN=1: 1 + (T_RP-1) + n·T_RFC cycles of commands/NOPs, where n = min(debt, AREF_PER_GRANT). flag_ref_end follows in the next cycle.
- Defaults, debt=2: PRE @k+1, AREF @k+3 and @k+7, flag_ref_end @k+11.
- Async reset mid-grant: the FSM aborts to IDLE and accumulated debt is discarded; the arbiter must reissue refresh after init.

## Test plan
- Hold flag_init_end=0 for 2000 cycles → debt=0, ref_req=0, aref_cmd=4'b0111 throughout; sdram_addr=13'h0400.
- Raise flag_init_end; no grant → debt=1 after 349 edges, ref_req=1 on the next edge; debt=2 after 698 edges.
- Defaults, debt=2, single-cycle ref_en at edge k:
  - ref_req=0 from k+1.
  - PRE at k+1, AREF at k+3 and k+7, all other cycles NOP.
  - flag_ref_end pulse at k+11; debt=0.
- PRE_EN=0, AREF_PER_GRANT=4, debt=3: AREF at k+1, k+5, k+9 → flag_ref_end at k+13, debt=0, ref_req stays 0.
- No grants for 10·349 cycles, MAX_DEBT=8:
  - ref_urgent rises when debt=7.
  - debt saturates at 8; debt_ovf=1 and remains 1 after a subsequent grant.
- Tick coinciding with an AREF cycle → debt unchanged that cycle.
- Assert s_rst during AREF_WAIT → all outputs reach reset values without a clock edge. After release, the FSM is IDLE and ref_req=0.
